// File: rtl/instr_encoder.sv
// RV32I instruction assembler: one-hot type plus fields in, 32-bit word plus byte address out,
// behind a one-entry valid/ready output register.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       enc_c;
  logic              onehot_c;
  logic              accept_c;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_c  = in_valid && in_ready;
  assign onehot_c  = (in_type != 9'd0) && ((in_type & (in_type - 9'd1)) == 9'd0);

  // Field packing per instruction format; non-one-hot types fall to default.
  always_comb begin
    enc_c = 32'd0;
    case (in_type)
      9'b1_0000_0000: enc_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      9'b0_1000_0000: enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      9'b0_0100_0000: enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      9'b0_0010_0000: enc_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      9'b0_0001_0000: enc_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], OP_B};
      9'b0_0000_1000: enc_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, OP_JAL};
      9'b0_0000_0100: enc_c = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      9'b0_0000_0010: enc_c = {in_imm[31:12], in_rd, OP_LUI};
      9'b0_0000_0001: enc_c = {in_imm[31:12], in_rd, OP_AUIPC};
      default:        enc_c = 32'd0;
    endcase
  end

  // Output register, address counter and sticky error next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (err_clr) err_d = 1'b0;
    if (accept_c) begin
      if (onehot_c) begin
        out_valid_d = 1'b1;
        out_instr_d = enc_c;
        out_addr_d  = cnt_q;
        cnt_d       = cnt_q + STEP;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_addr_q  <= BASE;
      cnt_q       <= BASE;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, handshake, addressing, error flag.
module tb_instr_encoder;

  localparam logic [8:0] T_R = 9'h100, T_I = 9'h080, T_LD = 9'h040, T_S = 9'h020, T_B = 9'h010;
  localparam logic [8:0] T_JAL = 9'h008, T_JALR = 9'h004, T_LUI = 9'h002, T_AUIPC = 9'h001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic in_ready, out_valid, err;
  logic [8:0] in_type = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0] in_funct3 = '0;
  logic [6:0] in_funct7 = '0;
  logic [31:0] in_imm = '0, out_instr;
  logic [9:0] out_addr;

  logic w_in_valid = 1'b0, w_out_ready = 1'b0;
  logic w_in_ready, w_out_valid, w_err;
  logic [31:0] w_out_instr;
  logic [3:0] w_out_addr;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_clr(err_clr)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_type(T_I),
    .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0), .in_funct3(3'd0), .in_funct7(7'd0),
    .in_imm(32'd1), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr), .err(w_err), .err_clr(1'b0)
  );

  task automatic set_bundle(input logic [8:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; w_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_addr !== 10'h000 || err !== 1'b0 || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL reset: valid=%b addr=%h err=%b instr=%h, want 0 000 0 00000000",
               out_valid, out_addr, err, out_instr);
    end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    set_bundle(T_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== 10'h000) begin
      fails++;
      $display("FAIL add: valid=%b instr=%h addr=%h, want 1 002081B3 000", out_valid, out_instr, out_addr);
    end
    @(negedge clk); in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain: valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  t[3]   = '{T_I, T_S, T_B};
    logic [4:0]  rd[3]  = '{5'd1, 5'd0, 5'd0};
    logic [4:0]  r1[3]  = '{5'd0, 5'd1, 5'd0};
    logic [4:0]  r2[3]  = '{5'd0, 5'd2, 5'd0};
    logic [2:0]  f3[3]  = '{3'd0, 3'd2, 3'd0};
    logic [31:0] imm[3] = '{32'd5, 32'd8, 32'hFFFF_FFFC};
    logic [31:0] exp[3] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_bundle(t[i], rd[i], r1[i], r2[i], f3[i], 7'd0, imm[i]);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== exp[i] || out_addr !== 10'(i * 4)) begin
        fails++;
        $display("FAIL b2b[%0d]: valid=%b instr=%h addr=%h, want 1 %h %h",
                 i, out_valid, out_instr, out_addr, exp[i], 10'(i * 4));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_formats();
    logic [8:0]  t[5]   = '{T_JAL, T_LUI, T_JALR, T_LD, T_AUIPC};
    logic [4:0]  rd[5]  = '{5'd1, 5'd5, 5'd1, 5'd5, 5'd1};
    logic [4:0]  r1[5]  = '{5'd0, 5'd0, 5'd2, 5'd6, 5'd0};
    logic [2:0]  f3[5]  = '{3'd0, 3'd0, 3'd7, 3'd2, 3'd0};
    logic [31:0] imm[5] = '{32'd8, 32'h12345000, 32'd0, 32'hFFFF_FFFF, 32'hABCDE123};
    logic [31:0] exp[5] = '{32'h008000EF, 32'h123452B7, 32'h000100E7, 32'hFFF32283, 32'hABCDE097};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      set_bundle(t[i], rd[i], r1[i], 5'd0, f3[i], 7'd0, imm[i]);
      step();
      checks++;
      if (out_instr !== exp[i] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL fmt[%0d]: valid=%b instr=%h, want 1 %h", i, out_valid, out_instr, exp[i]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    set_bundle(T_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    @(negedge clk);
    set_bundle(T_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00500093 ||
          out_addr !== 10'h000) begin
        fails++;
        $display("FAIL stall[%0d]: rdy=%b valid=%b instr=%h addr=%h, want 0 1 00500093 000",
                 c, in_ready, out_valid, out_instr, out_addr);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== 10'h004) begin
      fails++;
      $display("FAIL release: valid=%b instr=%h addr=%h, want 1 002081B3 004",
               out_valid, out_instr, out_addr);
    end
    @(negedge clk); in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL release_drain: valid=%b want 0", out_valid); end
  endtask

  task automatic test_invalid_type();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    set_bundle(9'b000000011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL bad_type: valid=%b err=%b, want 0 1", out_valid, err);
    end
    @(negedge clk);
    set_bundle(T_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 10'h000 || err !== 1'b1) begin
      fails++;
      $display("FAIL after_bad: valid=%b addr=%h err=%b, want 1 000 1", out_valid, out_addr, err);
    end
    @(negedge clk); in_valid = 1'b0; err_clr = 1'b1;
    step();
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clr: err=%b want 0", err); end
    @(negedge clk); in_valid = 1'b1; in_type = 9'd0;
    step();
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL set_wins: err=%b valid=%b, want 1 0", err, out_valid);
    end
    @(negedge clk); in_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    logic [3:0] exp[5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    do_reset();
    w_out_ready = 1'b1; w_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (w_out_valid !== 1'b1 || w_out_addr !== exp[i]) begin
        fails++;
        $display("FAIL wrap[%0d]: valid=%b addr=%h, want 1 %h", i, w_out_valid, w_out_addr, exp[i]);
      end
    end
    @(negedge clk); w_out_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (w_out_valid !== 1'b0 || w_out_addr !== 4'h0) begin
      fails++;
      $display("FAIL async_rst: valid=%b addr=%h, want 0 0", w_out_valid, w_out_addr);
    end
    @(negedge clk); rst = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    @(negedge clk); w_in_valid = 1'b1;
    step();
    checks++;
    if (w_out_addr !== 4'h0 || w_out_valid !== 1'b1) begin
      fails++;
      $display("FAIL post_rst: valid=%b addr=%h, want 1 0", w_out_valid, w_out_addr);
    end
    @(negedge clk); w_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_formats();
    test_backpressure();
    test_invalid_type();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
